pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_raw_match.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings, register/opcode
// constants and the RAW dependency rule used by hazard and forwarding logic.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LU    = 2'd1,
    ST_MDU   = 2'd2,
    ST_FLUSH = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_X0     = 5'd0;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

  // R-type MUL/DIV/REM decode, for the decoder that feeds id_is_mdu_i
  function automatic logic is_mdu_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == MDU_FUNCT7);
  endfunction

  // A source depends on a producer when it is really read, the producer
  // writes a register, and that register is not the hard-wired x0
  function automatic logic raw_dep(input logic [4:0] rd, input logic rd_we,
                                   input logic [4:0] rs, input logic rs_used);
    return rd_we && (rd != REG_X0) && rs_used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_raw_match.sv
// raw_match: combinational rd-vs-rs1/rs2 comparator with x0 exclusion and
// used-gating; shared by hazard detection and forwarding.
module raw_match
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rd_addr_i,
  input  logic       rd_we_i,
  input  logic [4:0] rs1_addr_i,
  input  logic       rs1_used_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs2_used_i,
  output logic       hit_o
);

  assign hit_o = raw_dep(rd_addr_i, rd_we_i, rs1_addr_i, rs1_used_i)
               | raw_dep(rd_addr_i, rd_we_i, rs2_addr_i, rs2_used_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer beside decode. Handles load-use
// hazards, multi-cycle MDU sequencing with timeout, and the post-redirect
// IF/ID kill window. Optional perf counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_MAX      = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             id_is_mdu_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_we_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             mdu_done_i,
  output logic             if_stall_o,
  output logic             id_stall_o,
  output logic             id_bubble_o,
  output logic             if_kill_o,
  output logic             mdu_start_o,
  output logic             mdu_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_cycles_o
);

  localparam int unsigned        WCNT_W    = $clog2(MDU_MAX + 1);
  localparam logic [2:0]         FCNT_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(MDU_MAX - 1);

  hz_state_e         state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mdu_err_q, mdu_err_d;

  logic raw_hit, lu_hit;
  logic stall, bubble, kill, start;

  raw_match u_raw_match (
    .rd_addr_i  (ex_rd_addr_i),
    .rd_we_i    (ex_rd_we_i),
    .rs1_addr_i (id_rs1_addr_i),
    .rs1_used_i (id_rs1_used_i),
    .rs2_addr_i (id_rs2_addr_i),
    .rs2_used_i (id_rs2_used_i),
    .hit_o      (raw_hit)
  );

  assign lu_hit = id_valid_i & ex_is_load_i & raw_hit;

  // Next-state and same-cycle control outputs; redirect > load-use > MDU launch
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    wcnt_d    = wcnt_q;
    mdu_err_d = mdu_err_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    kill      = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      ST_RUN, ST_LU: begin
        if (ex_redirect_i) begin
          kill    = 1'b1;
          bubble  = 1'b1;
          state_d = ST_FLUSH;
          fcnt_d  = FCNT_LOAD;
        end else if ((state_q == ST_RUN) && lu_hit) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_LU;
        end else if ((state_q == ST_RUN) && id_valid_i && id_is_mdu_i) begin
          start   = 1'b1;
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_MDU;
          wcnt_d  = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDU: begin
        if (mdu_done_i) begin
          state_d = ST_RUN;
        end else if (wcnt_q == WCNT_LAST) begin
          mdu_err_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        kill = 1'b1;
        if (ex_redirect_i) begin
          fcnt_d = FCNT_LOAD;
        end else if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state, wait/flush counters and sticky timeout flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      mdu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      mdu_err_q <= mdu_err_d;
    end
  end

  // Outputs are forced low while reset is held so no launch escapes
  assign if_stall_o  = stall  & rst_n_i;
  assign id_stall_o  = stall  & rst_n_i;
  assign id_bubble_o = bubble & rst_n_i;
  assign if_kill_o   = kill   & rst_n_i;
  assign mdu_start_o = start  & rst_n_i;
  assign mdu_err_o   = mdu_err_q;
  assign state_o     = state_q;

  // EX only holds bubbles while the MDU runs, so a redirect there is a bug upstream
  a_no_redirect_in_mdu: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) (state_q == ST_MDU) |-> !ex_redirect_i);

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counts of stalled and killed cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (if_stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_kill_o  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Perf counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_cycles_o = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random stimulus,
// all checked against a cycle-level reference model of the control rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MM = 64;
  localparam int unsigned FC = 2;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 32;
`endif
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_is_mdu;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          ex_we, ex_load, ex_redirect, mdu_done;
  logic          if_stall_o, id_stall_o, id_bubble_o, if_kill_o, mdu_start_o, mdu_err_o;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cycles_o, flush_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 run, 1 load-use, 2 MDU wait, 3 flush
  int     m_mode, m_left, m_total;
  bit     m_err;
  longint m_stalls, m_kills;

  pipe_hazard_ctrl #(.MDU_MAX(MM), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_valid_i(id_valid), .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used), .id_is_mdu_i(id_is_mdu),
    .ex_rd_addr_i(ex_rd), .ex_rd_we_i(ex_we), .ex_is_load_i(ex_load),
    .ex_redirect_i(ex_redirect), .mdu_done_i(mdu_done),
    .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .id_bubble_o(id_bubble_o),
    .if_kill_o(if_kill_o), .mdu_start_o(mdu_start_o), .mdu_err_o(mdu_err_o),
    .state_o(state_o), .stall_cycles_o(stall_cycles_o), .flush_cycles_o(flush_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_total = 0; m_err = 1'b0; m_stalls = 0; m_kills = 0;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_is_mdu = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_we = 0; ex_load = 0;
    ex_redirect = 0; mdu_done = 0;
  endtask

  // One clock: observe outputs mid-cycle, predict them, then advance the model.
  // Vector layout: {state[1:0], if_stall, id_stall, id_bubble, if_kill, mdu_start, mdu_err}
  task automatic step(output logic [7:0] obs, output logic [7:0] want);
    bit lu, st, bub, kill, start, err_n;
    int nm, nl, nt;
    #3;
    lu = id_valid && ex_load && ex_we && (ex_rd != 0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    st = 0; bub = 0; kill = 0; start = 0; err_n = 0;
    nm = m_mode; nl = m_left; nt = m_total;
    if ((m_mode == 0 || m_mode == 1) && ex_redirect) begin
      kill = 1; bub = 1; nm = 3; nl = FC;
    end else if (m_mode == 0 && lu) begin
      st = 1; bub = 1; nm = 1;
    end else if (m_mode == 0 && id_valid && id_is_mdu) begin
      start = 1; st = 1; bub = 1; nm = 2; nt = 1;
    end else if (m_mode == 1) begin
      nm = 0;
    end else if (m_mode == 2) begin
      if (mdu_done) nm = 0;
      else if (m_total == MM) begin err_n = 1; nm = 0; end
      else begin st = 1; bub = 1; nt = m_total + 1; end
    end else if (m_mode == 3) begin
      kill = 1;
      if (ex_redirect) nl = FC;
      else begin nl = m_left - 1; if (nl == 0) nm = 0; end
    end
    obs  = {state_o, if_stall_o, id_stall_o, id_bubble_o, if_kill_o, mdu_start_o, mdu_err_o};
    want = {2'(m_mode), st, st, bub, kill, start, m_err};
    @(posedge clk);
    m_mode = nm; m_left = nl; m_total = nt;
    if (err_n) m_err = 1'b1;
    if (st && m_stalls < CMAX) m_stalls++;
    if (kill && m_kills < CMAX) m_kills++;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #2;
    set_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 0;
    set_idle();
    id_valid = 1; id_is_mdu = 1; ex_redirect = 1;
    #23;
    obs = {state_o, if_stall_o, id_stall_o, id_bubble_o, if_kill_o, mdu_start_o, mdu_err_o};
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 00000000", obs);
    end
    n_checks++;
    if (stall_cycles_o !== '0 || flush_cycles_o !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cycles_o, flush_cycles_o);
    end
    set_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    logic [7:0] obs, want;
    int stalls;
    // rd=x5 load, ID reads rs1=x5
    ex_load = 1; ex_we = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    step(obs, want);
    n_checks++;
    if (obs !== want || obs !== 8'b00111000) begin
      n_fail++; $display("FAIL lu_hit: got %b required %b", obs, want);
    end
    ex_load = 0; ex_we = 0;
    step(obs, want);
    n_checks++;
    if (obs !== want || obs !== 8'b01000000) begin
      n_fail++; $display("FAIL lu_stall_state: got %b required %b", obs, want);
    end
    set_idle();
    step(obs, want);
    n_checks++;
    if (obs !== want) begin
      n_fail++; $display("FAIL lu_return: got %b required %b", obs, want);
    end
    // rd = x0 never stalls
    ex_load = 1; ex_we = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; id_rs1_used = 1;
    step(obs, want);
    n_checks++;
    if (obs !== want || obs !== 8'h00) begin
      n_fail++; $display("FAIL lu_x0: got %b required %b", obs, want);
    end
    // source matches but unused
    ex_rd = 7; id_rs1 = 7; id_rs1_used = 0; id_rs2 = 7; id_rs2_used = 0;
    step(obs, want);
    n_checks++;
    if (obs !== want || obs !== 8'h00) begin
      n_fail++; $display("FAIL lu_unused: got %b required %b", obs, want);
    end
    // both sources equal rd: one stall only
    stalls = 0;
    id_rs1_used = 1; id_rs2_used = 1;
    for (int i = 0; i < 3; i++) begin
      step(obs, want);
      if (obs[5]) stalls++;
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL lu_both cyc %0d: got %b required %b", i, obs, want);
      end
      if (i == 0) begin ex_load = 0; ex_we = 0; end
      if (i == 1) set_idle();
    end
    n_checks++;
    if (stalls !== 1) begin
      n_fail++; $display("FAIL lu_both_count: got %0d required 1", stalls);
    end
  endtask

  task automatic test_mdu();
    logic [7:0] obs, want;
    int starts, stalls;
    starts = 0; stalls = 0;
    id_valid = 1; id_is_mdu = 1;
    for (int i = 0; i < 6; i++) begin
      mdu_done = (i == 4);
      if (i == 5) set_idle();
      step(obs, want);
      if (obs[1]) starts++;
      if (obs[5]) stalls++;
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL mdu cyc %0d: got %b required %b", i, obs, want);
      end
      if (i == 2) begin
        n_checks++;
        if (state_o !== 2'd2) begin
          n_fail++; $display("FAIL mdu_state: got %0d required 2", state_o);
        end
      end
    end
    n_checks++;
    if (starts !== 1 || stalls !== 4) begin
      n_fail++; $display("FAIL mdu_counts: got start=%0d stall=%0d required 1/4", starts, stalls);
    end
  endtask

  task automatic test_flush();
    logic [7:0] obs, want;
    int kills;
    kills = 0;
    for (int i = 0; i < 5; i++) begin
      ex_redirect = (i == 0);
      step(obs, want);
      if (obs[2]) kills++;
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL flush cyc %0d: got %b required %b", i, obs, want);
      end
    end
    n_checks++;
    if (kills !== 3) begin
      n_fail++; $display("FAIL flush_len: got %0d required 3", kills);
    end
    kills = 0;
    for (int i = 0; i < 6; i++) begin
      ex_redirect = (i == 0 || i == 1);
      step(obs, want);
      if (obs[2]) kills++;
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL flush_ext cyc %0d: got %b required %b", i, obs, want);
      end
    end
    ex_redirect = 0;
    n_checks++;
    if (kills !== 4) begin
      n_fail++; $display("FAIL flush_ext_len: got %0d required 4", kills);
    end
  endtask

  task automatic test_priority();
    logic [7:0] obs, want;
    ex_redirect = 1; ex_load = 1; ex_we = 1; ex_rd = 3;
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1; id_is_mdu = 1;
    step(obs, want);
    n_checks++;
    if (obs !== want || obs !== 8'b00001100) begin
      n_fail++; $display("FAIL priority: got %b required %b", obs, want);
    end
    set_idle();
    for (int i = 0; i < 3; i++) begin
      step(obs, want);
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL priority_drain cyc %0d: got %b required %b", i, obs, want);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, want;
    for (int i = 0; i < 600; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) != 0;
      id_rs2_used = $urandom_range(0, 1) != 0;
      id_is_mdu   = ($urandom_range(0, 5) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_we       = $urandom_range(0, 1) != 0;
      ex_load     = $urandom_range(0, 1) != 0;
      ex_redirect = (m_mode != 2) && ($urandom_range(0, 9) == 0);
      mdu_done    = (m_mode == 2) && ($urandom_range(0, 4) == 0);
      step(obs, want);
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL random cyc %0d: got %b required %b", i, obs, want);
      end
    end
    set_idle();
    for (int i = 0; i < 80 && m_mode != 0; i++) begin
      mdu_done = (m_mode == 2);
      step(obs, want);
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL random_drain cyc %0d: got %b required %b", i, obs, want);
      end
    end
    mdu_done = 0;
    n_checks++;
    if (state_o !== 2'd0) begin
      n_fail++; $display("FAIL random_drain_bound: got state %0d required 0", state_o);
    end
  endtask

  task automatic test_perf(input string tag);
    longint es, ek;
`ifdef PIPE_HAZARD_PERF_CNT_EN
    es = m_stalls; ek = m_kills;
`else
    es = 0; ek = 0;
`endif
    n_checks++;
    if (longint'(stall_cycles_o) !== es || longint'(flush_cycles_o) !== ek) begin
      n_fail++;
      $display("FAIL perf_%s: got stall=%0d flush=%0d required %0d/%0d",
               tag, stall_cycles_o, flush_cycles_o, es, ek);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] obs, want;
    int stalls;
    stalls = 0;
    apply_reset();
    id_valid = 1; id_is_mdu = 1;
    for (int i = 0; i < MM + 5; i++) begin
      step(obs, want);
      if (obs[5]) stalls++;
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL timeout cyc %0d: got %b required %b", i, obs, want);
      end
      if (i > 0 && m_mode == 0) break;
    end
    set_idle();
    for (int i = 0; i < 3; i++) begin
      step(obs, want);
      n_checks++;
      if (obs !== want || obs !== 8'b00000001) begin
        n_fail++; $display("FAIL timeout_sticky cyc %0d: got %b required %b", i, obs, want);
      end
    end
    n_checks++;
    if (stalls !== MM) begin
      n_fail++; $display("FAIL timeout_len: got %0d required %0d", stalls, MM);
    end
  endtask

  task automatic test_reset_mid_mdu();
    logic [7:0] obs, want;
    id_valid = 1; id_is_mdu = 1;
    for (int i = 0; i < 3; i++) begin
      step(obs, want);
      n_checks++;
      if (obs !== want) begin
        n_fail++; $display("FAIL rst_mdu_pre cyc %0d: got %b required %b", i, obs, want);
      end
    end
    #2;
    rst_n = 0;
    #1;
    obs = {state_o, if_stall_o, id_stall_o, id_bubble_o, if_kill_o, mdu_start_o, mdu_err_o};
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL rst_mdu_async: got %b required 00000000", obs);
    end
    model_reset();
    set_idle();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step(obs, want);
      n_checks++;
      if (obs !== want || obs[1] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mdu_post cyc %0d: got %b required %b", i, obs, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_mdu();
    test_flush();
    test_priority();
    test_random();
    test_perf("random");
    test_timeout();
    test_perf("timeout");
    test_reset_mid_mdu();
    test_perf("after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
